// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the single-clock and the dual-clock FIFOs.
package fifo_pkg;

   // STD registers rd_data on each pop; FWFT shows the head word combinationally.
   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

endpackage

// File: rtl/sync_fifo_if.sv
// Bundle of the producer/consumer signals of sync_fifo; master = user side, slave = FIFO.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);

   // Handshake: wr_en is a request that is taken only when full is low at the edge;
   // rd_en is taken only when empty is low. Refused requests only set the sticky
   // overflow/underflow flag, nothing else changes.
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Contents are deliberately not reset; nothing can read a slot before it is written.
   logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with selectable STD/FWFT read mode, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int         DATA_WIDTH    = 8,
   parameter int         ADDR_WIDTH    = 4,
   parameter fifo_mode_e MODE          = FIFO_STD,
   parameter int         AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int         AEMPTY_THRESH = 2
) (
   input  logic      clk,
   input  logic      rst,
   sync_fifo_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   if (AFULL_THRESH > DEPTH) begin : g_chk_afull
      $error("sync_fifo: AFULL_THRESH must not exceed DEPTH");
   end
   if (AEMPTY_THRESH >= DEPTH) begin : g_chk_aempty
      $error("sync_fifo: AEMPTY_THRESH must be below DEPTH");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  full, empty, wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Status is decoded from count_q alone so no input has a combinational path to it.
   always_comb begin
      full        = (count_q == DEPTH_C);
      empty       = (count_q == '0);
      wr_acc      = bus.wr_en && !full;
      rd_acc      = bus.rd_en && !empty;
      wr_ptr_d    = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d    = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d     = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CNT_ONE;
      end
      overflow_d  = overflow_q  || (bus.wr_en && full);
      underflow_d = underflow_q || (bus.rd_en && empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (bus.wr_data),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is shown directly; its value while empty is meaningless.
      assign bus.rd_data = mem_rdata;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

      always_comb begin
         rd_data_d = rd_acc ? mem_rdata : rd_data_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_q <= '0;
         end else begin
            rd_data_q <= rd_data_d;
         end
      end

      assign bus.rd_data = rd_data_q;
   end

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AFULL_C);
   assign bus.almost_empty = (count_q <= AEMPTY_C);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one STD and one FWFT instance driven with identical stimulus.
module tb_sync_fifo;
   import fifo_pkg::*;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] wr_data;

   sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();
   sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f_if ();

   assign s_if.wr_en   = wr_en;
   assign s_if.wr_data = wr_data;
   assign s_if.rd_en   = rd_en;
   assign f_if.wr_en   = wr_en;
   assign f_if.wr_data = wr_data;
   assign f_if.rd_en   = rd_en;

   sync_fifo #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE(FIFO_STD),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) u_std (
      .clk (clk),
      .rst (rst),
      .bus (s_if.slave)
   );

   sync_fifo #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE(FIFO_FWFT),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) u_fwft (
      .clk (clk),
      .rst (rst),
      .bus (f_if.slave)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: the queue holds exactly the words written and not yet read.
   logic [DW-1:0] exp_q[$];
   logic          m_ovf    = 1'b0;
   logic          m_unf    = 1'b0;
   logic [DW-1:0] m_std_rd = '0;

   typedef struct {
      logic          rst;
      logic          wr;
      logic          rd;
      logic [DW-1:0] d;
      logic [AW:0]   cnt;
      logic          full;
      logic          empty;
      logic          af;
      logic          ae;
      logic          ovf;
      logic          unf;
      logic [DW-1:0] rd_data;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic r, input logic w, input logic rd, input logic [DW-1:0] d,
                          input int cnt, input logic ovf, input logic unf, input logic [DW-1:0] rdd);
      vec_t v;
      v.rst = r; v.wr = w; v.rd = rd; v.d = d;
      v.cnt = (AW+1)'(cnt);
      v.full = (cnt == DEPTH);
      v.empty = (cnt == 0);
      v.af = (cnt >= AF);
      v.ae = (cnt <= AE);
      v.ovf = ovf; v.unf = unf; v.rd_data = rdd;
      vecs.push_back(v);
   endtask

   task automatic model_edge();
      int c;
      c = exp_q.size();
      if (rst) begin
         exp_q.delete();
         m_ovf    = 1'b0;
         m_unf    = 1'b0;
         m_std_rd = '0;
      end else begin
         if (rd_en && c != 0) m_std_rd = exp_q.pop_front();
         if (wr_en && c != DEPTH) exp_q.push_back(wr_data);
         if (wr_en && c == DEPTH) m_ovf = 1'b1;
         if (rd_en && c == 0) m_unf = 1'b1;
      end
   endtask

   task automatic chk_bus(input string p, input logic [AW:0] cnt, input logic f, input logic e,
                          input logic af, input logic ae, input logic ov, input logic un);
      int c;
      c = exp_q.size();
      chk({p, "_count"}, 32'(cnt), 32'(c));
      chk({p, "_full"}, 32'(f), 32'(c == DEPTH));
      chk({p, "_empty"}, 32'(e), 32'(c == 0));
      chk({p, "_almost_full"}, 32'(af), 32'(c >= AF));
      chk({p, "_almost_empty"}, 32'(ae), 32'(c <= AE));
      chk({p, "_overflow"}, 32'(ov), 32'(m_ovf));
      chk({p, "_underflow"}, 32'(un), 32'(m_unf));
   endtask

   task automatic check_model();
      chk_bus("std", s_if.count, s_if.full, s_if.empty, s_if.almost_full, s_if.almost_empty,
              s_if.overflow, s_if.underflow);
      chk_bus("fwft", f_if.count, f_if.full, f_if.empty, f_if.almost_full, f_if.almost_empty,
              f_if.overflow, f_if.underflow);
      chk("std_rd_data", 32'(s_if.rd_data), 32'(m_std_rd));
      if (exp_q.size() != 0) chk("fwft_rd_data", 32'(f_if.rd_data), 32'(exp_q[0]));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic drive(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
      rst = r; wr_en = w; rd_en = rd; wr_data = d;
   endtask

   initial begin
      int n_wr;
      drive(1'b1, 1'b0, 1'b0, '0);

      // Directed table: reset, fill, overflow while full, drain, underflow, reset.
      add_vec(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
      for (int k = 0; k < DEPTH; k++) add_vec(0, 1, 0, DW'(k), k + 1, 0, 0, 8'h00);
      add_vec(0, 1, 0, 8'hAA, 16, 1, 0, 8'h00);
      add_vec(0, 0, 0, 8'h00, 16, 1, 0, 8'h00);
      for (int k = 0; k < DEPTH; k++) add_vec(0, 0, 1, 8'h00, 15 - k, 1, 0, DW'(k));
      add_vec(0, 0, 1, 8'h00, 0, 1, 1, 8'h0F);
      add_vec(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].d);
         step();
         chk($sformatf("v%0d_count", i), 32'(s_if.count), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_full", i), 32'(s_if.full), 32'(vecs[i].full));
         chk($sformatf("v%0d_empty", i), 32'(f_if.empty), 32'(vecs[i].empty));
         chk($sformatf("v%0d_afull", i), 32'(f_if.almost_full), 32'(vecs[i].af));
         chk($sformatf("v%0d_aempty", i), 32'(s_if.almost_empty), 32'(vecs[i].ae));
         chk($sformatf("v%0d_ovf", i), 32'(s_if.overflow), 32'(vecs[i].ovf));
         chk($sformatf("v%0d_unf", i), 32'(f_if.underflow), 32'(vecs[i].unf));
         chk($sformatf("v%0d_rd_data", i), 32'(s_if.rd_data), 32'(vecs[i].rd_data));
      end

      // FWFT: written word appears without rd_en; one pop empties it again.
      drive(1'b0, 1'b1, 1'b0, 8'h5C);
      step();
      chk("fwft_5c_data", 32'(f_if.rd_data), 32'h5C);
      chk("fwft_5c_empty", 32'(f_if.empty), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      step();
      chk("fwft_5c_hold", 32'(f_if.rd_data), 32'h5C);
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      step();
      chk("fwft_pop_empty", 32'(f_if.empty), 32'h1);
      chk("std_5c_data", 32'(s_if.rd_data), 32'h5C);

      // Simultaneous read+write while empty, then while full.
      drive(1'b0, 1'b1, 1'b1, 8'h11);
      step();
      chk("sim_empty_count", 32'(s_if.count), 32'h1);
      chk("sim_empty_unf", 32'(s_if.underflow), 32'h1);
      for (int k = 0; k < DEPTH - 1; k++) begin
         drive(1'b0, 1'b1, 1'b0, DW'($urandom_range(0, 255)));
         step();
      end
      drive(1'b0, 1'b1, 1'b1, 8'h99);
      step();
      chk("sim_full_count", 32'(s_if.count), 32'(DEPTH - 1));
      chk("sim_full_ovf", 32'(s_if.overflow), 32'h1);
      chk("sim_full_rd", 32'(s_if.rd_data), 32'h11);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      step();
      chk("rst_clear_ovf", 32'(s_if.overflow), 32'h0);
      chk("rst_clear_unf", 32'(f_if.underflow), 32'h0);

      // Random traffic, alternating write-heavy and read-heavy phases across wrap-around.
      n_wr = 0;
      for (int i = 0; i < 400; i++) begin
         bit heavy_wr;
         heavy_wr = ((i / 25) % 2) == 0;
         drive(1'b0,
               heavy_wr ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3),
               heavy_wr ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8),
               DW'($urandom_range(0, 255)));
         if (wr_en) n_wr++;
         step();
      end
      chk("rand_enough_writes", 32'(n_wr >= 40), 32'h1);

      // Reset mid-stream with count=7 and a write pending on the same edge.
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      step();
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, 1'b1, 1'b0, DW'(8'h70 + k));
         step();
      end
      chk("mid_count7", 32'(s_if.count), 32'h7);
      drive(1'b1, 1'b1, 1'b0, 8'hEE);
      step();
      chk("mid_rst_count", 32'(s_if.count), 32'h0);
      chk("mid_rst_empty", 32'(f_if.empty), 32'h1);
      drive(1'b0, 1'b1, 1'b0, 8'h33);
      step();
      chk("mid_fwft_first", 32'(f_if.rd_data), 32'h33);
      drive(1'b0, 1'b1, 1'b0, 8'h44);
      step();
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      step();
      chk("mid_std_first", 32'(s_if.rd_data), 32'h33);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
